// File: rtl/hazard_monitor_pkg.sv
// Shared definitions for the hazard monitor: state encoding, default thresholds
// and the debug view exported alongside the functional outputs.
package hazard_monitor_pkg;

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    WARN   = 2'd1,
    CRIT   = 2'd2,
    EVAC   = 2'd3
  } state_e;

  localparam int DEF_N         = 8;
  localparam int DEF_TEMP_WARN = 90;
  localparam int DEF_O2_WARN   = 20;
  localparam int DEF_PWR_WARN  = 10;
  localparam int DEF_SH_WARN   = 20;
  localparam int DEF_FATAL_DEB = 3;
  localparam int DEF_EVAC_CNT  = 16;

  // Debounce count in the debug view is zero-extended to this fixed width.
  localparam int DBG_CNT_W = 8;

  typedef struct packed {
    state_e                 state;
    logic                   acked;
    logic                   warn;
    logic                   fatal_q;
    logic [DBG_CNT_W-1:0]   deb_count;
  } hm_dbg_t;

  // Bits needed to hold 0..limit; never less than one bit.
  function automatic int deb_width(input int limit);
    int w;
    w = 1;
    if (limit > 1) w = $clog2(limit + 1);
    return w;
  endfunction

endpackage

// File: rtl/hazard_monitor_if.sv
// Telemetry in / command out bundle between life support and the hazard monitor.
// Plain level signals sampled every rising clk edge; no handshake is involved.
interface hazard_monitor_if #(
  parameter int n = hazard_monitor_pkg::DEF_N
) ();
  import hazard_monitor_pkg::*;

  logic [n-1:0] shield;
  logic [n-1:0] temp;
  logic [n-1:0] power;
  logic [n-1:0] o2;
  logic         fatal;
  logic         ack;

  logic [1:0]   state;
  logic         alarm;
  logic         evac;
  logic [n-1:0] countdown;
  hm_dbg_t      dbg;

  modport master (
    output shield, temp, power, o2, fatal, ack,
    input  state, alarm, evac, countdown, dbg
  );

  modport slave (
    input  shield, temp, power, o2, fatal, ack,
    output state, alarm, evac, countdown, dbg
  );

endinterface

// File: rtl/hazard_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W     = 2,
  parameter int LIMIT = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         at_max
);

  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != LIM)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count  = count_q;
  assign at_max = (count_q == LIM);

endmodule

// File: rtl/hazard_monitor.sv
// Cabin hazard monitor: threshold warnings, debounced fatal flag, and a
// NORMAL/WARN/CRIT/EVAC escalation with an evacuation countdown.
module hazard_monitor
  import hazard_monitor_pkg::*;
#(
  parameter int n         = DEF_N,
  parameter int TEMP_WARN = DEF_TEMP_WARN,
  parameter int O2_WARN   = DEF_O2_WARN,
  parameter int PWR_WARN  = DEF_PWR_WARN,
  parameter int SH_WARN   = DEF_SH_WARN,
  parameter int FATAL_DEB = DEF_FATAL_DEB,
  parameter int EVAC_CNT  = DEF_EVAC_CNT
) (
  input  logic             clk,
  input  logic             rst,
  hazard_monitor_if.slave  bus
);

  localparam int           DEB_W    = deb_width(FATAL_DEB);
  localparam logic [n-1:0] TEMP_TH  = n'(TEMP_WARN);
  localparam logic [n-1:0] O2_TH    = n'(O2_WARN);
  localparam logic [n-1:0] PWR_TH   = n'(PWR_WARN);
  localparam logic [n-1:0] SH_TH    = n'(SH_WARN);
  localparam logic [n-1:0] CNT_LOAD = n'(EVAC_CNT);

  logic             warn;
  logic [DEB_W-1:0] deb_count;
  logic             fatal_q;

  state_e           state_q,     state_d;
  logic [n-1:0]     countdown_q, countdown_d;
  logic             acked_q,     acked_d;
  logic             alarm_q,     alarm_d;
  logic             evac_q,      evac_d;

  always_comb begin
    warn = (bus.temp   >= TEMP_TH) ||
           (bus.o2     <= O2_TH)   ||
           (bus.power  <= PWR_TH)  ||
           (bus.shield <= SH_TH);
  end

  // fatal_q only rises after FATAL_DEB consecutive cycles of fatal=1.
  sat_counter #(
    .W     (DEB_W),
    .LIMIT (FATAL_DEB)
  ) u_fatal_deb (
    .clk    (clk),
    .rst    (rst),
    .inc    (bus.fatal),
    .clr    (!bus.fatal),
    .count  (deb_count),
    .at_max (fatal_q)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      NORMAL: begin
        if (fatal_q)   state_d = CRIT;
        else if (warn) state_d = WARN;
      end
      WARN: begin
        if (fatal_q)    state_d = CRIT;
        else if (!warn) state_d = NORMAL;
      end
      CRIT: begin
        // Exhausted countdown escalates even if fatal clears the same cycle.
        if (countdown_q == '0) state_d = EVAC;
        else if (!bus.fatal)   state_d = WARN;
      end
      EVAC: begin
        state_d = EVAC;
      end
      default: begin
        state_d = NORMAL;
      end
    endcase
  end

  // Outputs are computed from the next state so they line up with state_q.
  always_comb begin
    countdown_d = CNT_LOAD;
    if ((state_q == CRIT) && (state_d == CRIT)) begin
      countdown_d = (countdown_q == '0) ? '0 : (countdown_q - 1'b1);
    end

    acked_d = acked_q;
    if (state_d != state_q) begin
      acked_d = 1'b0;
    end else if ((state_q == WARN) && bus.ack) begin
      acked_d = 1'b1;
    end

    alarm_d = ((state_d == WARN) && !acked_d) ||
              (state_d == CRIT) ||
              (state_d == EVAC);
    evac_d  = (state_d == EVAC);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= NORMAL;
      countdown_q <= CNT_LOAD;
      acked_q     <= 1'b0;
      alarm_q     <= 1'b0;
      evac_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      countdown_q <= countdown_d;
      acked_q     <= acked_d;
      alarm_q     <= alarm_d;
      evac_q      <= evac_d;
    end
  end

  assign bus.state     = state_q;
  assign bus.alarm     = alarm_q;
  assign bus.evac      = evac_q;
  assign bus.countdown = countdown_q;

  always_comb begin
    bus.dbg           = '0;
    bus.dbg.state     = state_q;
    bus.dbg.acked     = acked_q;
    bus.dbg.warn      = warn;
    bus.dbg.fatal_q   = fatal_q;
    bus.dbg.deb_count = DBG_CNT_W'(deb_count);
  end

endmodule

// File: tb/tb_hazard_monitor.sv
// Directed bench for hazard_monitor: thresholds, ack handling, fatal debounce,
// countdown to EVAC and asynchronous reset.
module tb_hazard_monitor;

  localparam int N = 8;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  hazard_monitor_if #(.n(N)) bus ();

  hazard_monitor #(.n(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_env(input int t, input int o, input int p, input int s);
    bus.temp   = N'(t);
    bus.o2     = N'(o);
    bus.power  = N'(p);
    bus.shield = N'(s);
  endtask

  task automatic check_out(input string tag, input int st, input int al,
                           input int ev, input int cd);
    chk({tag, ".state"},     32'(bus.state),     32'(st));
    chk({tag, ".alarm"},     32'(bus.alarm),     32'(al));
    chk({tag, ".evac"},      32'(bus.evac),      32'(ev));
    chk({tag, ".countdown"}, 32'(bus.countdown), 32'(cd));
  endtask

  // Driver / stimulus
  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst       = 1'b1;
    bus.fatal = 1'b0;
    bus.ack   = 1'b0;
    set_env(20, 50, 50, 50);

    // Reset takes effect without a clock edge.
    #1 rst = 1'b0;
    #2;
    check_out("rst_async", 0, 0, 0, 16);
    chk("rst_async.deb", 32'(bus.dbg.deb_count), 0);
    chk("rst_async.acked", 32'(bus.dbg.acked), 0);
    tick();
    check_out("rst_hold", 0, 0, 0, 16);
    rst = 1'b1;

    // Single-cycle temperature warning; first edge after release updates state.
    bus.temp = 8'd95; tick(); check_out("s42_warn", 1, 1, 0, 16);
    bus.temp = 8'd80; tick(); check_out("s42_norm", 0, 0, 0, 16);

    // Threshold boundaries.
    bus.temp = 8'd89;   tick(); chk("temp89",   32'(bus.state), 0);
    bus.temp = 8'd90;   tick(); chk("temp90",   32'(bus.state), 1);
    bus.temp = 8'd80;   tick(); chk("temp80",   32'(bus.state), 0);
    bus.o2 = 8'd20;     tick(); chk("o2_20",    32'(bus.state), 1);
    bus.o2 = 8'd21;     tick(); chk("o2_21",    32'(bus.state), 0);
    bus.power = 8'd10;  tick(); chk("pwr_10",   32'(bus.state), 1);
    bus.power = 8'd11;  tick(); chk("pwr_11",   32'(bus.state), 0);
    bus.shield = 8'd20; tick(); chk("sh_20",    32'(bus.state), 1);
    bus.shield = 8'd21; tick(); chk("sh_21",    32'(bus.state), 0);
    set_env(20, 50, 50, 50);

    // Acknowledge silences WARN; a fresh warning re-raises the alarm.
    bus.temp = 8'd95; tick(); check_out("s43_warn", 1, 1, 0, 16);
    bus.ack = 1'b1;   tick(); check_out("s43_ack", 1, 0, 0, 16);
    chk("s43_ack.acked", 32'(bus.dbg.acked), 1);
    bus.ack = 1'b0;   tick(); check_out("s43_hold", 1, 0, 0, 16);
    bus.temp = 8'd80; tick(); check_out("s43_norm", 0, 0, 0, 16);
    chk("s43_norm.acked", 32'(bus.dbg.acked), 0);
    bus.ack = 1'b1;   tick(); check_out("s43_ack_norm", 0, 0, 0, 16);
    chk("s43_ack_norm.acked", 32'(bus.dbg.acked), 0);
    bus.ack = 1'b0; bus.temp = 8'd95; tick(); check_out("s43_rewarn", 1, 1, 0, 16);
    bus.temp = 8'd80; tick(); chk("s43_back", 32'(bus.state), 0);

    // Short fatal pulse never qualifies.
    bus.fatal = 1'b1; tick(); chk("s44_deb1", 32'(bus.dbg.deb_count), 1);
    chk("s44_st1", 32'(bus.state), 0);
    tick(); chk("s44_deb2", 32'(bus.dbg.deb_count), 2);
    chk("s44_st2", 32'(bus.state), 0);
    bus.fatal = 1'b0; tick(); chk("s44_deb0", 32'(bus.dbg.deb_count), 0);
    repeat (4) tick();
    check_out("s44_end", 0, 0, 0, 16);

    // Ack coinciding with WARN->CRIT: the transition wins.
    bus.temp = 8'd95; tick(); chk("r36_warn", 32'(bus.state), 1);
    bus.fatal = 1'b1;
    repeat (3) tick();
    chk("r36_pre.state", 32'(bus.state), 1);
    chk("r36_pre.deb", 32'(bus.dbg.deb_count), 3);
    bus.ack = 1'b1; tick(); check_out("r36_crit", 2, 1, 0, 16);
    chk("r36_crit.acked", 32'(bus.dbg.acked), 0);
    bus.ack = 1'b0; bus.fatal = 1'b0; tick(); check_out("r36_warn2", 1, 1, 0, 16);
    chk("r36_warn2.deb", 32'(bus.dbg.deb_count), 0);
    bus.temp = 8'd20; tick(); chk("r36_norm", 32'(bus.state), 0);

    // Fatal held: CRIT on the 4th edge, EVAC 17 edges later.
    bus.fatal = 1'b1;
    repeat (3) tick();
    chk("s45_pre.state", 32'(bus.state), 0);
    chk("s45_pre.fatal_q", 32'(bus.dbg.fatal_q), 1);
    tick(); check_out("s45_crit", 2, 1, 0, 16);
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk($sformatf("s45_cd%0d", k), 32'(bus.countdown), 32'(16 - k));
    end
    chk("s45_cd0.state", 32'(bus.state), 2);
    tick(); check_out("s45_evac", 3, 1, 1, 16);
    bus.fatal = 1'b0; bus.ack = 1'b1;
    repeat (3) tick();
    check_out("s45_terminal", 3, 1, 1, 16);
    bus.ack = 1'b0;

    // Asynchronous reset out of EVAC, between clock edges.
    #2 rst = 1'b0;
    #1 check_out("s47_rst", 0, 0, 0, 16);
    tick(); rst = 1'b1;
    tick(); check_out("s47_after", 0, 0, 0, 16);

    // fatal drops mid-countdown: back to WARN with countdown reloaded.
    bus.fatal = 1'b1;
    repeat (4) tick();
    chk("s46_crit", 32'(bus.state), 2);
    repeat (11) tick();
    chk("s46_cd5", 32'(bus.countdown), 5);
    bus.fatal = 1'b0; tick(); check_out("s46_warn", 1, 1, 0, 16);
    tick(); check_out("s46_norm", 0, 0, 0, 16);

    // countdown==0 beats fatal=0 in the same cycle.
    bus.fatal = 1'b1;
    repeat (4) tick();
    repeat (16) tick();
    check_out("prio_cd0", 2, 1, 0, 0);
    bus.fatal = 1'b0; tick(); check_out("prio_evac", 3, 1, 1, 16);
    #2 rst = 1'b0;
    #1 check_out("prio_rst", 0, 0, 0, 16);
    tick(); rst = 1'b1;

    // Reset in the middle of a countdown.
    bus.fatal = 1'b1;
    repeat (4) tick();
    repeat (3) tick();
    chk("midrst_cd13", 32'(bus.countdown), 13);
    #2 rst = 1'b0;
    #1 check_out("midrst", 0, 0, 0, 16);
    chk("midrst.deb", 32'(bus.dbg.deb_count), 0);
    bus.fatal = 1'b0;
    tick(); rst = 1'b1;
    tick(); check_out("midrst_after", 0, 0, 0, 16);

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
